// File: rtl/pcie_src_pkg.sv
// Shared constants and types for the PCIe virtual-channel source.
package pcie_src_pkg;

  localparam int unsigned PAYLOAD_W = 5;
  localparam int unsigned VC_BIT    = 5;
  localparam int unsigned DEPTH     = 4;

  typedef enum logic {
    VC0 = 1'b0,
    VC1 = 1'b1
  } vc_e;

endpackage

// File: rtl/vc_port_src.sv
// One source port: a FIFO per VC, pause/continue blocking, round-robin arbiter
// and a registered output stage.
module vc_port_src
  import pcie_src_pkg::*;
#(
  parameter int unsigned DEPTH = pcie_src_pkg::DEPTH
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  input  logic [VC_BIT:0]   i_data,
  output logic              o_ready,
  input  logic [1:0]        i_pause,
  input  logic [1:0]        i_continue,
  output logic              o_valid,
  output logic [VC_BIT:0]   o_data,
  output logic              o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [1:0]                w_push;
  logic [1:0]                w_pop;
  logic [1:0]                w_full;
  logic [1:0]                w_nempty;
  logic [1:0]                w_elig;
  logic [1:0][PAYLOAD_W-1:0] w_head;
  vc_e                       w_sel;

  logic [1:0]                r_blk;
  vc_e                       r_last;
  logic                      r_rdy_en;
  logic                      r_valid;
  logic [VC_BIT:0]           r_data;

  for (genvar v = 0; v < 2; v++) begin : g_vc
    logic [PAYLOAD_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]        r_wr_ptr;
    logic [AW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_cnt;

    assign w_push[v]   = i_valid & o_ready & (i_data[VC_BIT] == 1'(v));
    assign w_full[v]   = (r_cnt == CW'(DEPTH));
    assign w_nempty[v] = (r_cnt != '0);
    assign w_head[v]   = r_mem[r_rd_ptr];
    // Pause masks eligibility in the same cycle, before the flag registers it.
    assign w_elig[v]   = w_nempty[v] & ~r_blk[v] & ~i_pause[v];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_cnt    <= '0;
      end else begin
        if (w_push[v]) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop[v])  r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push[v] != w_pop[v]) r_cnt <= w_push[v] ? r_cnt + 1'b1 : r_cnt - 1'b1;
      end
    end

    always_ff @(posedge i_clk) begin
      if (w_push[v]) r_mem[r_wr_ptr] <= i_data[PAYLOAD_W-1:0];
    end
  end

  always_comb begin
    w_sel = VC0;
    if (w_elig[0] & w_elig[1]) begin
      w_sel = (r_last == VC0) ? VC1 : VC0;
    end else if (w_elig[1]) begin
      w_sel = VC1;
    end
    w_pop = '0;
    if (|w_elig) w_pop = (w_sel == VC1) ? 2'b10 : 2'b01;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_blk <= '0;
    end else begin
      // Pause wins over a simultaneous continue.
      r_blk <= i_pause | (r_blk & ~i_continue);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdy_en <= 1'b0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      r_last   <= VC1;
    end else begin
      r_rdy_en <= 1'b1;
      r_valid  <= |w_elig;
      if (|w_elig) begin
        r_data <= {w_sel, w_head[w_sel]};
        r_last <= w_sel;
      end else begin
        r_data <= '0;
      end
    end
  end

  assign o_ready = r_rdy_en & ~(|w_full);
  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_empty = ~(|w_nempty);

endmodule

// File: rtl/pcie_vc_source.sv
// Two independent VC source ports feeding the transaction layer, plus idle.
module pcie_vc_source
  import pcie_src_pkg::*;
#(
  parameter int unsigned DEPTH = pcie_src_pkg::DEPTH
) (
  input  logic            clk,
  input  logic            reset_L,
  input  logic            host_valid_p0,
  input  logic            host_valid_p1,
  input  logic [VC_BIT:0] host_data_p0,
  input  logic [VC_BIT:0] host_data_p1,
  output logic            host_ready_p0,
  output logic            host_ready_p1,
  input  logic            pause_VC0P0,
  input  logic            pause_VC1P0,
  input  logic            pause_VC0P1,
  input  logic            pause_VC1P1,
  input  logic            continue_VC0P0,
  input  logic            continue_VC1P0,
  input  logic            continue_VC0P1,
  input  logic            continue_VC1P1,
  output logic            valid_p0,
  output logic            valid_p1,
  output logic [VC_BIT:0] data_p0,
  output logic [VC_BIT:0] data_p1,
  output logic            idle
);

  logic w_empty_p0;
  logic w_empty_p1;

  vc_port_src #(
    .DEPTH(DEPTH)
  ) u_port0 (
    .i_clk     (clk),
    .i_rst_n   (reset_L),
    .i_valid   (host_valid_p0),
    .i_data    (host_data_p0),
    .o_ready   (host_ready_p0),
    .i_pause   ({pause_VC1P0, pause_VC0P0}),
    .i_continue({continue_VC1P0, continue_VC0P0}),
    .o_valid   (valid_p0),
    .o_data    (data_p0),
    .o_empty   (w_empty_p0)
  );

  vc_port_src #(
    .DEPTH(DEPTH)
  ) u_port1 (
    .i_clk     (clk),
    .i_rst_n   (reset_L),
    .i_valid   (host_valid_p1),
    .i_data    (host_data_p1),
    .o_ready   (host_ready_p1),
    .i_pause   ({pause_VC1P1, pause_VC0P1}),
    .i_continue({continue_VC1P1, continue_VC0P1}),
    .o_valid   (valid_p1),
    .o_data    (data_p1),
    .o_empty   (w_empty_p1)
  );

  assign idle = w_empty_p0 & w_empty_p1 & ~valid_p0 & ~valid_p1;

endmodule

// File: tb/tb_pcie_vc_source.sv
// Bench for pcie_vc_source: single-word vector table plus directed sequences,
// with a per-port scoreboard of expected output words.
module tb_pcie_vc_source;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       host_valid_p0, host_valid_p1;
  logic [5:0] host_data_p0, host_data_p1;
  logic       host_ready_p0, host_ready_p1;
  logic       pause_VC0P0, pause_VC1P0, pause_VC0P1, pause_VC1P1;
  logic       continue_VC0P0, continue_VC1P0, continue_VC0P1, continue_VC1P1;
  logic       valid_p0, valid_p1;
  logic [5:0] data_p0, data_p1;
  logic       idle;

  int checks = 0;
  int errors = 0;
  logic [5:0] q0[$];
  logic [5:0] q1[$];

  typedef struct {
    bit         port;
    logic [5:0] word;
    logic [5:0] exp;
  } vec_t;
  vec_t vecs[8];

  pcie_vc_source #(.DEPTH(4)) dut (
    .clk           (clk),
    .reset_L       (reset_L),
    .host_valid_p0 (host_valid_p0),
    .host_valid_p1 (host_valid_p1),
    .host_data_p0  (host_data_p0),
    .host_data_p1  (host_data_p1),
    .host_ready_p0 (host_ready_p0),
    .host_ready_p1 (host_ready_p1),
    .pause_VC0P0   (pause_VC0P0),
    .pause_VC1P0   (pause_VC1P0),
    .pause_VC0P1   (pause_VC0P1),
    .pause_VC1P1   (pause_VC1P1),
    .continue_VC0P0(continue_VC0P0),
    .continue_VC1P0(continue_VC1P0),
    .continue_VC0P1(continue_VC0P1),
    .continue_VC1P1(continue_VC1P1),
    .valid_p0      (valid_p0),
    .valid_p1      (valid_p1),
    .data_p0       (data_p0),
    .data_p1       (data_p1),
    .idle          (idle)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every output word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset_L === 1'b1 && valid_p0 === 1'b1) begin
      if (q0.size() == 0) check_bit("p0_unexpected_word", valid_p0, 1'b0);
      else check_word("p0_data", data_p0, q0.pop_front());
    end
    if (reset_L === 1'b1 && valid_p1 === 1'b1) begin
      if (q1.size() == 0) check_bit("p1_unexpected_word", valid_p1, 1'b0);
      else check_word("p1_data", data_p1, q1.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    host_valid_p0 = 0; host_valid_p1 = 0; host_data_p0 = '0; host_data_p1 = '0;
    pause_VC0P0 = 0; pause_VC1P0 = 0; pause_VC0P1 = 0; pause_VC1P1 = 0;
    continue_VC0P0 = 0; continue_VC1P0 = 0; continue_VC0P1 = 0; continue_VC1P1 = 0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    clear_inputs();
    q0.delete();
    q1.delete();
    tick();
    tick();
    reset_L = 1'b1;
    tick();
  endtask

  task automatic push(input bit p, input logic [5:0] w);
    int n = 0;
    while (((p ? host_ready_p1 : host_ready_p0) !== 1'b1) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check_bit("push_ready_timeout", p ? host_ready_p1 : host_ready_p0, 1'b1);
    if (p) begin host_valid_p1 = 1'b1; host_data_p1 = w; end
    else   begin host_valid_p0 = 1'b1; host_data_p0 = w; end
    tick();
    if (p) host_valid_p1 = 1'b0;
    else   host_valid_p0 = 1'b0;
  endtask

  initial begin
    logic [5:0] rr_exp[4];

    reset_L = 1'b0;
    clear_inputs();
    #2;
    check_bit("rst_valid_p0", valid_p0, 1'b0);
    check_bit("rst_valid_p1", valid_p1, 1'b0);
    check_word("rst_data_p0", data_p0, 6'h00);
    check_bit("rst_ready_p0", host_ready_p0, 1'b0);
    check_bit("rst_ready_p1", host_ready_p1, 1'b0);
    check_bit("rst_idle", idle, 1'b1);
    tick();
    tick();
    reset_L = 1'b1;
    check_bit("ready_before_first_edge", host_ready_p0, 1'b0);
    tick();
    check_bit("ready_p0_after_release", host_ready_p0, 1'b1);
    check_bit("ready_p1_after_release", host_ready_p1, 1'b1);

    // Single words: latency of two edges, data echoed as {vc, payload}.
    vecs[0] = '{1'b0, 6'h00, 6'h00};
    vecs[1] = '{1'b0, 6'h1F, 6'h1F};
    vecs[2] = '{1'b0, 6'h20, 6'h20};
    vecs[3] = '{1'b0, 6'h3F, 6'h3F};
    vecs[4] = '{1'b1, 6'h15, 6'h15};
    vecs[5] = '{1'b1, 6'h2A, 6'h2A};
    vecs[6] = '{1'b1, 6'h01, 6'h01};
    vecs[7] = '{1'b1, 6'h3E, 6'h3E};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].port) q1.push_back(vecs[i].exp);
      else q0.push_back(vecs[i].exp);
      push(vecs[i].port, vecs[i].word);
      check_bit($sformatf("vec%0d_valid_early", i), vecs[i].port ? valid_p1 : valid_p0, 1'b0);
      tick();
      check_bit($sformatf("vec%0d_valid", i), vecs[i].port ? valid_p1 : valid_p0, 1'b1);
      check_word($sformatf("vec%0d_data", i), vecs[i].port ? data_p1 : data_p0, vecs[i].exp);
      tick();
      check_bit($sformatf("vec%0d_idle", i), idle, 1'b1);
    end

    // Back-to-back throughput across both VCs.
    do_reset();
    q0.push_back(6'h05);
    q0.push_back(6'h25);
    push(1'b0, 6'h05);
    push(1'b0, 6'h25);
    check_bit("b2b_valid0", valid_p0, 1'b1);
    check_word("b2b_data0", data_p0, 6'h05);
    tick();
    check_bit("b2b_valid1", valid_p0, 1'b1);
    check_word("b2b_data1", data_p0, 6'h25);
    tick();
    check_bit("b2b_valid_end", valid_p0, 1'b0);

    // Round-robin tie with VC0 winning first after reset.
    do_reset();
    pause_VC0P0 = 1'b1;
    pause_VC1P0 = 1'b1;
    push(1'b0, 6'h01);
    push(1'b0, 6'h21);
    push(1'b0, 6'h02);
    push(1'b0, 6'h22);
    check_bit("rr_held", valid_p0, 1'b0);
    rr_exp = '{6'h01, 6'h21, 6'h02, 6'h22};
    for (int i = 0; i < 4; i++) q0.push_back(rr_exp[i]);
    pause_VC0P0 = 1'b0;
    pause_VC1P0 = 1'b0;
    continue_VC0P0 = 1'b1;
    continue_VC1P0 = 1'b1;
    tick();
    continue_VC0P0 = 1'b0;
    continue_VC1P0 = 1'b0;
    check_bit("rr_flag_edge", valid_p0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_word($sformatf("rr_order%0d", i), data_p0, rr_exp[i]);
    end
    tick();
    check_int("rr_drained", q0.size(), 0);

    // Pause pulse blocks VC0P1 until continue.
    do_reset();
    pause_VC0P1 = 1'b1;
    push(1'b1, 6'h03);
    pause_VC0P1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit($sformatf("pause_blocked%0d", i), valid_p1, 1'b0);
    end
    q1.push_back(6'h03);
    continue_VC0P1 = 1'b1;
    tick();
    continue_VC0P1 = 1'b0;
    check_bit("cont_edge1", valid_p1, 1'b0);
    tick();
    check_bit("cont_edge2_valid", valid_p1, 1'b1);
    check_word("cont_edge2_data", data_p1, 6'h03);

    // Full buffer drops ready; a fifth offered word is ignored.
    do_reset();
    pause_VC1P0 = 1'b1;
    for (int i = 1; i <= 4; i++) push(1'b0, 6'(6'h20 + i));
    check_bit("full_ready_low", host_ready_p0, 1'b0);
    host_valid_p0 = 1'b1;
    host_data_p0  = 6'h30;
    tick();
    tick();
    check_bit("full_ready_still_low", host_ready_p0, 1'b0);
    host_valid_p0 = 1'b0;
    for (int i = 1; i <= 4; i++) q0.push_back(6'(6'h20 + i));
    pause_VC1P0 = 1'b0;
    continue_VC1P0 = 1'b1;
    tick();
    continue_VC1P0 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check_int("full_drained", q0.size(), 0);
    check_bit("full_ready_back", host_ready_p0, 1'b1);

    // Simultaneous pause and continue leaves the VC blocked.
    do_reset();
    pause_VC0P0 = 1'b1;
    continue_VC0P0 = 1'b1;
    push(1'b0, 6'h07);
    pause_VC0P0 = 1'b0;
    continue_VC0P0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_bit($sformatf("pc_blocked%0d", i), valid_p0, 1'b0);
    end
    q0.push_back(6'h07);
    continue_VC0P0 = 1'b1;
    tick();
    continue_VC0P0 = 1'b0;
    tick();
    check_word("pc_release_data", data_p0, 6'h07);

    // Mid-stream reset discards buffered and in-flight words.
    do_reset();
    pause_VC0P0 = 1'b1;
    push(1'b0, 6'h01);
    push(1'b0, 6'h02);
    push(1'b0, 6'h03);
    q0.push_back(6'h2A);
    push(1'b0, 6'h2A);
    tick();
    check_bit("mid_inflight_valid", valid_p0, 1'b1);
    #2;
    reset_L = 1'b0;
    q0.delete();
    #1;
    check_bit("mid_valid_async", valid_p0, 1'b0);
    check_word("mid_data_async", data_p0, 6'h00);
    check_bit("mid_idle_async", idle, 1'b1);
    check_bit("mid_ready_async", host_ready_p0, 1'b0);
    pause_VC0P0 = 1'b0;
    tick();
    reset_L = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_bit("mid_idle_after", idle, 1'b1);

    check_int("final_q0_empty", q0.size(), 0);
    check_int("final_q1_empty", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pcie_vc_source.md
PCIE_VC_SOURCE -- requirements
Module: pcie_vc_source

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per VC buffer (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_L, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have ports host_valid_p0 and host_valid_p1, input, 1 bit each: host word offered on port 0 / port 1.
REQ-005 SHALL have ports host_data_p0 and host_data_p1, input, 6 bits each: bit 5 is the VC select (0 = VC0, 1 = VC1); bits 4:0 are the payload.
REQ-006 SHALL have ports host_ready_p0 and host_ready_p1, output, 1 bit each: port accepts a word this cycle.
REQ-007 SHALL have inputs pause_VC0P0, pause_VC1P0, pause_VC0P1 and pause_VC1P1, 1 bit each: downstream FIFO almost-full indication per VC and port.
REQ-008 SHALL have inputs continue_VC0P0, continue_VC1P0, continue_VC0P1 and continue_VC1P1, 1 bit each: downstream FIFO drained indication per VC and port.
REQ-009 SHALL have outputs valid_p0 and valid_p1, 1 bit each: word present on data_pX.
REQ-010 SHALL have outputs data_p0 and data_p1, 6 bits each: {vc, payload}, matching the downstream transaction-layer input format.
REQ-011 SHALL have output idle, 1 bit: all four buffers are empty and valid_p0 and valid_p1 are both low.

Function
REQ-012 SHALL keep one DEPTH-entry FIFO per VC per port, four in total.
REQ-013 SHALL drive host_ready_pX high only when neither VC buffer of port X is full; the value depends on no input in the same cycle.
REQ-014 SHALL write payload bits 4:0 into the VC buffer selected by bit 5 at each edge where host_valid_pX and host_ready_pX are both high.
REQ-015 SHALL ignore words offered while host_ready_pX is low, with no state change.
REQ-016 SHALL keep a blocked flag per VC per port:
- pause sets the flag;
- continue clears the flag;
- pause and continue high in the same cycle set the flag;
- the flag is updated at the clock edge.
REQ-017 SHALL treat a VC as eligible only when its buffer is non-empty, its blocked flag is low and its pause input is low in the current cycle (pause takes effect immediately).
REQ-018 SHALL arbitrate per port:
- if one VC is eligible, pop it;
- if both VCs are eligible, pop the VC not served last (round-robin);
- if none is eligible, pop nothing.
REQ-019 SHALL register outputs: on a pop, the next edge loads valid_pX=1 and data_pX={vc, head payload}; with no pop, it loads valid_pX=0 and data_pX=0.
REQ-020 SHALL give a minimum latency of 2 edges from a word accepted at edge N to that word on data_pX after edge N+1, with the buffer empty and the VC unblocked beforehand.
REQ-021 SHALL support a push and a pop on the same buffer in the same cycle: occupancy is unchanged and order is preserved.
REQ-022 SHALL allow a push into a full buffer in the same cycle as a pop from it only through the ready rule; since ready is low whenever either buffer is full, overflow is impossible.
REQ-023 SHALL wrap buffer pointers modulo DEPTH and track full/empty with a DEPTH+1-valued occupancy count.
REQ-024 SHALL operate port 0 and port 1 fully independently.

Reset
REQ-025 SHALL, while reset_L is low, asynchronously:
- empty all buffers;
- clear all blocked flags;
- set each round-robin pointer to "VC1 last" so that VC0 wins the first tie;
- drive valid_pX=0, data_pX=0, host_ready_pX=0 and idle=1.
REQ-026 SHALL, on reset assertion mid-stream, discard buffered and in-flight words; outputs reach their reset values with no clock edge.
REQ-027 SHALL drive host_ready_pX high at the first edge after reset_L deasserts.

Structure
REQ-028 SHALL place in shared package pcie_src_pkg: constant PAYLOAD_W=5, constant VC_BIT=5, constant DEPTH default 4, and a VC enum (VC0=0, VC1=1).
REQ-029 SHALL use one sub-module, vc_port_src (two buffers, blocked flags, arbiter, output register), instantiated once per port; the top contains only instantiation and the idle logic.

Verification
REQ-030 SHALL cover back-to-back throughput: P0 words 0x05 (VC0) then 0x25 (VC1), no pause -> data_p0 = 0x05, then 0x25 on consecutive cycles, with valid_p0 high both cycles.
REQ-031 SHALL cover round-robin: VC0 holds 0x01 and 0x02, VC1 holds 0x21 and 0x22 -> output order 0x01, 0x21, 0x02, 0x22.
REQ-032 SHALL cover pause and continue: pause_VC0P1 pulses with VC0P1 holding 0x03 -> no VC0 output; after continue_VC0P1 pulses, 0x03 appears two edges later.
REQ-033 SHALL cover full/ready: with pause_VC1P0 held, push 4 VC1 words -> host_ready_p0=0 after the 4th; a 5th offered word is not stored.
REQ-034 SHALL cover simultaneous pause and continue on VC0P0 -> VC0P0 stays blocked.
REQ-035 SHALL cover mid-stream reset: reset_L low with 3 words buffered -> valid_p0=0 immediately and idle=1; after release, no old word appears.
